// File: rtl/izh_step_sequencer_if.sv
// Signal bundle between the step sequencer and its environment: start/status, current memory,
// izhikevich core datapath and the spike event handshake.
interface izh_step_sequencer_if #(
  parameter int unsigned IDX_W = 4
);
  logic             start;
  logic             busy;
  logic             done;
  logic [IDX_W:0]   spike_count;
  logic [IDX_W-1:0] i_addr;
  logic [16:0]      i_data;
  logic [16:0]      core_v;
  logic [16:0]      core_u;
  logic [16:0]      core_i;
  logic [16:0]      core_v_prime;
  logic [16:0]      core_u_prime;
  logic             core_fired;
  logic             spike_valid;
  logic             spike_ready;
  logic [IDX_W-1:0] spike_idx;

  modport master (
    input  start, i_data, core_v_prime, core_u_prime, core_fired, spike_ready,
    output busy, done, spike_count, i_addr, core_v, core_u, core_i, spike_valid, spike_idx
  );

  modport slave (
    output start, i_data, core_v_prime, core_u_prime, core_fired, spike_ready,
    input  busy, done, spike_count, i_addr, core_v, core_u, core_i, spike_valid, spike_idx
  );
endinterface

// File: rtl/izh_step_sequencer.sv
// Time-step controller for a single izhikevich core: owns v/u of every neuron and walks the
// core over them in index order, writing results back and emitting spike events.
module izh_step_sequencer #(
  parameter int unsigned N_NEURONS = 16,
  parameter int unsigned IDX_W     = 4,
  parameter logic [16:0] V_INIT    = 17'h14100,
  parameter logic [16:0] U_INIT    = 17'h10D00
) (
  input logic                  clk,
  input logic                  rst_n,
  izh_step_sequencer_if.master bus
);

  localparam logic [2:0] StInit  = 3'd0;
  localparam logic [2:0] StIdle  = 3'd1;
  localparam logic [2:0] StRead  = 3'd2;
  localparam logic [2:0] StExec  = 3'd3;
  localparam logic [2:0] StWb    = 3'd4;
  localparam logic [2:0] StSpike = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_NEURONS - 1);
  localparam logic [IDX_W:0]   CntMax  = (IDX_W + 1)'(N_NEURONS);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [16:0]      core_v_q, core_v_d;
  logic [16:0]      core_u_q, core_u_d;
  logic             spike_valid_q, spike_valid_d;
  logic [IDX_W-1:0] spike_idx_q, spike_idx_d;

  logic [16:0] v_mem [N_NEURONS];
  logic [16:0] u_mem [N_NEURONS];
  logic        mem_we;
  logic [16:0] mem_v_wdata;
  logic [16:0] mem_u_wdata;

  logic             last_idx;
  logic [2:0]       adv_state;
  logic [IDX_W-1:0] adv_idx;

  assign last_idx = (idx_q == LastIdx);

  // Shared "move to the next neuron" step used by WB (no spike) and by SPIKE on acceptance.
  always_comb begin
    adv_state = StRead;
    adv_idx   = idx_q + IDX_W'(1);
    if (last_idx) begin
      adv_state = StDone;
      adv_idx   = idx_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    core_v_d      = core_v_q;
    core_u_d      = core_u_q;
    spike_valid_d = spike_valid_q;
    spike_idx_d   = spike_idx_q;
    mem_we        = 1'b0;
    mem_v_wdata   = bus.core_v_prime;
    mem_u_wdata   = bus.core_u_prime;

    case (state_q)
      StInit: begin
        mem_we      = 1'b1;
        mem_v_wdata = V_INIT;
        mem_u_wdata = U_INIT;
        if (last_idx) begin
          idx_d   = '0;
          state_d = StIdle;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StIdle: begin
        if (bus.start) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        core_v_d = v_mem[idx_q];
        core_u_d = u_mem[idx_q];
        state_d  = StExec;
      end
      StExec: begin
        // The core samples core_v/core_u/core_i at the end of this cycle.
        state_d = StWb;
      end
      StWb: begin
        mem_we = 1'b1;
        if (bus.core_fired) begin
          spike_idx_d   = idx_q;
          spike_valid_d = 1'b1;
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + (IDX_W + 1)'(1);
          end
          state_d = StSpike;
        end else begin
          idx_d   = adv_idx;
          state_d = adv_state;
        end
      end
      StSpike: begin
        if (bus.spike_ready) begin
          spike_valid_d = 1'b0;
          idx_d         = adv_idx;
          state_d       = adv_state;
        end
      end
      StDone: begin
        idx_d   = '0;
        state_d = StIdle;
      end
      default: begin
        idx_d   = '0;
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StInit;
      idx_q         <= '0;
      cnt_q         <= '0;
      core_v_q      <= '0;
      core_u_q      <= '0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      core_v_q      <= core_v_d;
      core_u_q      <= core_u_d;
      spike_valid_q <= spike_valid_d;
      spike_idx_q   <= spike_idx_d;
    end
  end

  // State storage is deliberately not reset; INIT rewrites every entry after each reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      v_mem[idx_q] <= mem_v_wdata;
      u_mem[idx_q] <= mem_u_wdata;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.spike_count = cnt_q;
  assign bus.i_addr      = idx_q;
  assign bus.core_v      = core_v_q;
  assign bus.core_u      = core_u_q;
  assign bus.core_i      = bus.i_data;
  assign bus.spike_valid = spike_valid_q;
  assign bus.spike_idx   = spike_idx_q;

endmodule

// File: tb/tb_izh_step_sequencer.sv
// Self-checking bench for izh_step_sequencer: core stub v'=v+1, u'=u+i[3:0], fired=i[8],
// table-driven and randomized steps checked against a per-neuron timing/value model.
module tb_izh_step_sequencer;
  localparam int N = 16;
  localparam logic [16:0] V_INIT = 17'h14100;
  localparam logic [16:0] U_INIT = 17'h10D00;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  izh_step_sequencer_if #(.IDX_W(4)) bus ();

  izh_step_sequencer #(
    .N_NEURONS(N),
    .IDX_W    (4),
    .V_INIT   (V_INIT),
    .U_INIT   (U_INIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [16:0] i_mem [N];
  always @(posedge clk) bus.i_data <= i_mem[bus.i_addr];

  // Core stub: registered outputs, sampled every edge like the real core.
  always @(posedge clk) begin
    bus.core_v_prime <= bus.core_v + 17'd1;
    bus.core_u_prime <= bus.core_u + {13'd0, bus.core_i[3:0]};
    bus.core_fired   <= bus.core_i[8];
  end

  logic [16:0] mv [N];
  logic [16:0] mu [N];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] mask;
    int          stall;
    bit          poke;
    int          exp_cnt;
    int          exp_lat;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = V_INIT;
      mu[k] = U_INIT;
    end
  endtask

  task automatic check_init_release();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("busy_during_init", bus.busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_init", bus.busy, 0);
  endtask

  // One time step. stall < 0 picks a random stall per spike; exp_lat/exp_cnt < 0 use the model.
  task automatic run_step(input logic [15:0] mask, input int stall_cfg, input bit poke,
                          input int exp_cnt, input int exp_lat);
    logic [16:0] v0 [N];
    logic [16:0] u0 [N];
    logic [16:0] held_v;
    int edges, exec_edge, k_cur, stall_left, stalls, vcyc, nspk;
    bit awaiting, pending, poked, got_done;
    for (int k = 0; k < N; k++) begin
      i_mem[k] = 17'(k) | (mask[k] ? 17'h100 : 17'h0);
      v0[k]    = mv[k];
      u0[k]    = mu[k];
    end
    nspk = $countones(mask);
    exec_edge = 2; k_cur = 0; stall_left = 0; stalls = 0; vcyc = 0;
    awaiting = 0; pending = 0; poked = 0; got_done = 0; held_v = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.spike_ready = 1'b1;
    @(posedge clk);
    edges = 1;
    while (edges < 400) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        got_done = 1;
        break;
      end
      if (!awaiting && k_cur < N && edges == exec_edge) begin
        chk("core_v_at_exec", bus.core_v, v0[k_cur]);
        chk("core_u_at_exec", bus.core_u, u0[k_cur]);
        chk("i_addr_at_exec", bus.i_addr, k_cur);
        if (mask[k_cur]) awaiting = 1;
        else begin
          k_cur++;
          exec_edge += 3;
        end
      end
      if (poke && !poked && bus.i_addr == 4'd7) begin
        bus.start = 1'b1;
        poked = 1;
      end
      if (bus.spike_valid) begin
        vcyc++;
        if (!pending) begin
          chk("spike_expected", awaiting, 1);
          chk("spike_idx", bus.spike_idx, k_cur);
          pending = 1;
          held_v = bus.core_v;
          stall_left = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
        end else begin
          chk("spike_idx_hold", bus.spike_idx, k_cur);
          chk("i_addr_hold", bus.i_addr, k_cur);
          chk("core_v_hold", bus.core_v, held_v);
        end
        if (stall_left > 0) begin
          bus.spike_ready = 1'b0;
          stall_left--;
          stalls++;
        end else begin
          bus.spike_ready = 1'b1;
          pending = 0;
          awaiting = 0;
          k_cur++;
          exec_edge = edges + 2;
        end
      end else begin
        bus.spike_ready = (stall_cfg < 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk);
      edges++;
    end
    chk("done_seen", got_done, 1);
    if (got_done) begin
      chk("done_latency", edges, (exp_lat >= 0) ? exp_lat : 3 * N + 1 + nspk + stalls);
      chk("spike_count", bus.spike_count, (exp_cnt >= 0) ? exp_cnt : nspk);
      chk("neurons_visited", k_cur, N);
      chk("spike_valid_cycles", vcyc, nspk + stalls);
      @(posedge clk);
      @(negedge clk);
      chk("done_one_cycle", bus.done, 0);
      chk("idle_after_done", bus.busy, 0);
      if (poke) begin
        repeat (3) @(negedge clk);
        chk("start_not_queued", bus.busy, 0);
      end
    end
    bus.spike_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      mv[k] = v0[k] + 17'd1;
      mu[k] = u0[k] + 17'(k);
    end
  endtask

  initial begin
    vecs[0] = '{16'h0000, 0,  1'b0, 0,  49};
    vecs[1] = '{16'h0000, 0,  1'b0, 0,  49};
    vecs[2] = '{16'h0020, 0,  1'b0, 1,  50};
    vecs[3] = '{16'h0008, 10, 1'b0, 1,  60};
    vecs[4] = '{16'h8000, 3,  1'b0, 1,  53};
    vecs[5] = '{16'h0000, 0,  1'b1, 0,  49};
    vecs[6] = '{16'hFFFF, 0,  1'b0, 16, 65};

    bus.start = 1'b0;
    bus.spike_ready = 1'b1;
    for (int k = 0; k < N; k++) i_mem[k] = 17'(k);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_spike_valid", bus.spike_valid, 0);
    chk("rst_spike_idx", bus.spike_idx, 0);
    chk("rst_spike_count", bus.spike_count, 0);
    chk("rst_core_v", bus.core_v, 0);
    chk("rst_core_u", bus.core_u, 0);
    chk("rst_i_addr", bus.i_addr, 0);
    check_init_release();
    model_reset();

    for (int t = 0; t < 7; t++)
      run_step(vecs[t].mask, vecs[t].stall, vecs[t].poke, vecs[t].exp_cnt, vecs[t].exp_lat);

    // Abort a step at idx 7 with reset; INIT must restore every neuron.
    for (int k = 0; k < N; k++) i_mem[k] = 17'(k) | ((k == 2) ? 17'h100 : 17'h0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 100 && bus.i_addr != 4'd7; c++) @(negedge clk);
    chk("abort_reached_idx7", bus.i_addr, 7);
    chk("abort_count_before", bus.spike_count, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1);
    chk("abort_done", bus.done, 0);
    chk("abort_spike_valid", bus.spike_valid, 0);
    chk("abort_spike_count", bus.spike_count, 0);
    chk("abort_core_v", bus.core_v, 0);
    chk("abort_core_u", bus.core_u, 0);
    chk("abort_i_addr", bus.i_addr, 0);
    repeat (2) @(posedge clk);
    check_init_release();
    model_reset();
    run_step(16'hFFFF, 0, 1'b0, 16, 65);

    for (int r = 0; r < 20; r++) run_step(16'($urandom), -1, 1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
